tb_axi_delay: RTL

TB_AXI_DELAY -- requirements
Module: tb_axi_delay

---
 rtl/tb_axi_delay_pkg.sv | 68 ++++++
 rtl/tb_axi_delay_lane.sv | 98 +++++++++
 rtl/tb_axi_delay.sv | 97 +++++++++
 3 files changed

// File: rtl/tb_axi_delay_pkg.sv
// Shared types for the AXI response delay model: AXI channel/bundle structs and lane FSM states.
// The stall LFSR helpers exist only when TB_AXI_DELAY_STALL_EN is defined.
package tb_axi_delay_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  typedef enum logic {
    LaneWait = 1'b0,
    LaneShow = 1'b1
  } lane_state_e;

`ifdef TB_AXI_DELAY_STALL_EN
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  // Fibonacci form, taps 16,14,13,11, shifting towards bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
`endif

endpackage

// File: rtl/tb_axi_delay_lane.sv
// One delay lane: a Depth-entry FIFO of beats tagged with a release stamp, and a
// WAIT/SHOW FSM that presents the head once the free-running counter reaches its stamp.
module tb_axi_delay_lane
  import tb_axi_delay_pkg::*;
#(
  parameter type         beat_t   = logic,
  parameter int unsigned Depth    = 16,
  parameter int unsigned LatWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [LatWidth:0]   now_i,
  input  logic [LatWidth-1:0] lat_cycles_i,
  input  logic                stall_i,
  input  logic                in_valid_i,
  input  beat_t               in_beat_i,
  output logic                in_ready_o,
  output logic                out_valid_o,
  output beat_t               out_beat_o,
  input  logic                out_ready_i
);

  localparam int unsigned       PtrWidth  = $clog2(Depth);
  localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(Depth);

  typedef logic [LatWidth:0] stamp_t;

  beat_t               beat_mem  [Depth];
  stamp_t              stamp_mem [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrWidth:0]   count_q, count_d;
  lane_state_e         state_q, state_d;
  stamp_t              head_age;
  logic                push, pop, empty, full, eligible;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FullCount);
  assign in_ready_o = !full;
  assign push       = in_valid_i && !full;
  assign pop        = out_valid_o && out_ready_i;

  // Stamps live one bit wider than the latency, so "due" is just the sign of now - stamp.
  assign head_age = now_i - stamp_mem[rd_ptr_q];
  assign eligible = !empty && !head_age[LatWidth];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      beat_mem[wr_ptr_q]  <= in_beat_i;
      stamp_mem[wr_ptr_q] <= now_i + stamp_t'(lat_cycles_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LaneWait;
    else         state_q <= state_d;
  end

  // SHOW latches an offered head so neither stalls nor counter wrap can withdraw it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LaneWait: if (eligible && !stall_i && !out_ready_i) state_d = LaneShow;
      LaneShow: if (out_ready_i) state_d = LaneWait;
    endcase
  end

  always_comb begin
    out_valid_o = 1'b0;
    case (state_q)
      LaneWait: out_valid_o = eligible && !stall_i;
      LaneShow: out_valid_o = 1'b1;
    endcase
    out_beat_o = beat_mem[rd_ptr_q];
  end

endmodule

// File: rtl/tb_axi_delay.sv
// AXI response delay model: AW/W/AR pass straight through, B and R are held back by
// lat_cycles_i in independent lanes. TB_AXI_DELAY_STALL_EN adds LFSR stalls on the R lane.
module tb_axi_delay
  import tb_axi_delay_pkg::*;
#(
  parameter type         req_t    = axi_req_t,
  parameter type         rsp_t    = axi_rsp_t,
  parameter type         b_chan_t = axi_b_chan_t,
  parameter type         r_chan_t = axi_r_chan_t,
  parameter int unsigned Depth    = 16,
  parameter int unsigned LatWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [LatWidth-1:0] lat_cycles_i,
  input  req_t                slv_req_i,
  output rsp_t                slv_rsp_o,
  output req_t                mst_req_o,
  input  rsp_t                mst_rsp_i
);

  logic [LatWidth:0] now_q, now_d;
  logic              r_stall;
  logic              b_in_ready, r_in_ready;
  logic              b_out_valid, r_out_valid;
  b_chan_t           b_out_beat;
  r_chan_t           r_out_beat;

  assign now_d = now_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) now_q <= '0;
    else         now_q <= now_d;
  end

`ifdef TB_AXI_DELAY_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d  = lfsr16_next(lfsr_q);
  assign r_stall = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LfsrSeed;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign r_stall = 1'b0;
`endif

  tb_axi_delay_lane #(
    .beat_t  (b_chan_t),
    .Depth   (Depth),
    .LatWidth(LatWidth)
  ) i_b_lane (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .now_i       (now_q),
    .lat_cycles_i(lat_cycles_i),
    .stall_i     (1'b0),
    .in_valid_i  (mst_rsp_i.b_valid),
    .in_beat_i   (mst_rsp_i.b),
    .in_ready_o  (b_in_ready),
    .out_valid_o (b_out_valid),
    .out_beat_o  (b_out_beat),
    .out_ready_i (slv_req_i.b_ready)
  );

  tb_axi_delay_lane #(
    .beat_t  (r_chan_t),
    .Depth   (Depth),
    .LatWidth(LatWidth)
  ) i_r_lane (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .now_i       (now_q),
    .lat_cycles_i(lat_cycles_i),
    .stall_i     (r_stall),
    .in_valid_i  (mst_rsp_i.r_valid),
    .in_beat_i   (mst_rsp_i.r),
    .in_ready_o  (r_in_ready),
    .out_valid_o (r_out_valid),
    .out_beat_o  (r_out_beat),
    .out_ready_i (slv_req_i.r_ready)
  );

  always_comb begin
    mst_req_o         = slv_req_i;
    mst_req_o.b_ready = b_in_ready;
    mst_req_o.r_ready = r_in_ready;
    slv_rsp_o         = mst_rsp_i;
    slv_rsp_o.b_valid = b_out_valid;
    slv_rsp_o.b       = b_out_beat;
    slv_rsp_o.r_valid = r_out_valid;
    slv_rsp_o.r       = r_out_beat;
  end

endmodule
